// File: rtl/fpro_bus_pkg.sv
// Shared types and address-field constants for the MCS-to-FPro bridge family.
// Imported by the bridge top, its read-data mux and the bus interface.
package fpro_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } bridge_state_t;

    localparam int FP_DATA_W  = 32;
    localparam int FP_BE_W    = 4;

    // Byte-address fields: window tag, region select MSB, first word-address bit
    localparam int WIN_MSB    = 31;
    localparam int WIN_W      = 8;
    localparam int REGION_MSB = 23;
    localparam int WORD_LSB   = 2;

    // Wide enough for RD_LAT up to 7
    localparam int CNT_W      = 3;

    // Region-select width; a single region still needs a one-bit index
    function automatic int region_w(input int n_cs);
        return (n_cs > 1) ? $clog2(n_cs) : 1;
    endfunction

endpackage

// File: rtl/mcs_fpro_bridge_gen_if.sv
// MCS IO bus plus FPro bus bundle; the bridge takes the slave side, the CPU and
// FPro slaves together form the master side.
interface mcs_fpro_bridge_gen_if
    import fpro_bus_pkg::*;
#(
    parameter int N_CS   = 2,
    parameter int ADDR_W = 21
);

    // Handshake: io_addr_strobe is a one-cycle request qualified by exactly one of
    // io_read_strobe/io_write_strobe; io_ready is a one-cycle completion pulse and
    // io_read_data is valid with it; fp_wr/fp_rd are one-cycle pulses under fp_cs.
    logic                      io_addr_strobe;
    logic                      io_read_strobe;
    logic                      io_write_strobe;
    logic [FP_BE_W-1:0]        io_byte_enable;
    logic [31:0]               io_address;
    logic [FP_DATA_W-1:0]      io_write_data;
    logic [FP_DATA_W-1:0]      io_read_data;
    logic                      io_ready;

    logic [N_CS-1:0]           fp_cs;
    logic                      fp_wr;
    logic                      fp_rd;
    logic [FP_BE_W-1:0]        fp_be;
    logic [ADDR_W-1:0]         fp_addr;
    logic [FP_DATA_W-1:0]      fp_wr_data;
    logic [N_CS*FP_DATA_W-1:0] fp_rd_data;

    modport slave (
        input  io_addr_strobe, io_read_strobe, io_write_strobe, io_byte_enable,
        input  io_address, io_write_data,
        output io_read_data, io_ready,
        output fp_cs, fp_wr, fp_rd, fp_be, fp_addr, fp_wr_data,
        input  fp_rd_data
    );

    modport master (
        output io_addr_strobe, io_read_strobe, io_write_strobe, io_byte_enable,
        output io_address, io_write_data,
        input  io_read_data, io_ready,
        input  fp_cs, fp_wr, fp_rd, fp_be, fp_addr, fp_wr_data,
        output fp_rd_data
    );

endinterface

// File: rtl/fpro_rd_mux.sv
// N_CS-way read-data selector; region k occupies bits [32k+31:32k] of rd_data_all.
module fpro_rd_mux
    import fpro_bus_pkg::*;
#(
    parameter int N_CS  = 2,
    parameter int SEL_W = 1
) (
    input  logic [N_CS*FP_DATA_W-1:0] rd_data_all,
    input  logic [SEL_W-1:0]          region,
    output logic [FP_DATA_W-1:0]      rd_data
);

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N_CS; k++) begin
            if (region == SEL_W'(k)) begin
                rd_data = rd_data_all[k*FP_DATA_W +: FP_DATA_W];
            end
        end
    end

endmodule

// File: rtl/mcs_fpro_bridge_gen.sv
// Registered MCS IO bus to FPro bus bridge with N_CS chip-select regions,
// byte-enable forwarding, configurable read latency and a sticky error flag.
module mcs_fpro_bridge_gen
    import fpro_bus_pkg::*;
#(
    parameter logic [31:0] BRG_BASE = 32'hC000_0000,
    parameter int          N_CS     = 2,
    parameter int          ADDR_W   = 21,
    parameter int          RD_LAT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    mcs_fpro_bridge_gen_if.slave  bus,
    output logic                  busy,
    output logic                  bus_err,
    input  logic                  err_clr,
    output bridge_state_t         dbg_state
);

    localparam int            RW     = region_w(N_CS);
    localparam logic [RW:0]   N_CS_L = N_CS[RW:0];

    bridge_state_t          state_q, state_nx;
    logic [CNT_W-1:0]       cnt_q, cnt_nx;
    logic [RW-1:0]          region_q, region_nx;
    logic                   rd_q, rd_nx;

    logic [N_CS-1:0]        cs_q, cs_nx;
    logic                   wr_q, wr_nx;
    logic                   rdp_q, rdp_nx;
    logic [FP_BE_W-1:0]     be_q, be_nx;
    logic [ADDR_W-1:0]      addr_q, addr_nx;
    logic [FP_DATA_W-1:0]   wd_q, wd_nx;
    logic                   ready_q, ready_nx;
    logic [FP_DATA_W-1:0]   rdata_q, rdata_nx;
    logic                   busy_q, busy_nx;
    logic                   err_q, err_nx;
    logic                   err_set;

    logic                   hit;
    logic                   region_ok;
    logic                   one_dir;
    logic [RW-1:0]          region_dec;
    logic [N_CS-1:0]        cs_dec;
    logic [ADDR_W-1:0]      word_dec;
    logic [FP_DATA_W-1:0]   mux_data;

    // Address decode of the live MCS request
    always_comb begin
        hit        = (bus.io_address[WIN_MSB -: WIN_W] == BRG_BASE[WIN_MSB -: WIN_W]);
        region_dec = '0;
        if (N_CS > 1) begin
            region_dec = bus.io_address[REGION_MSB -: RW];
        end
        region_ok  = ({1'b0, region_dec} < N_CS_L);
        one_dir    = bus.io_read_strobe ^ bus.io_write_strobe;
        word_dec   = bus.io_address[WORD_LSB +: ADDR_W];
        cs_dec     = '0;
        for (int k = 0; k < N_CS; k++) begin
            cs_dec[k] = (region_dec == RW'(k));
        end
    end

    fpro_rd_mux #(
        .N_CS  (N_CS),
        .SEL_W (RW)
    ) u_rd_mux (
        .rd_data_all (bus.fp_rd_data),
        .region      (region_q),
        .rd_data     (mux_data)
    );

    always_comb begin
        state_nx  = state_q;
        cnt_nx    = cnt_q;
        region_nx = region_q;
        rd_nx     = rd_q;
        cs_nx     = cs_q;
        wr_nx     = 1'b0;
        rdp_nx    = 1'b0;
        be_nx     = be_q;
        addr_nx   = addr_q;
        wd_nx     = wd_q;
        ready_nx  = 1'b0;
        rdata_nx  = rdata_q;
        err_set   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.io_addr_strobe) begin
                    if (hit && region_ok && one_dir) begin
                        state_nx  = REQ;
                        region_nx = region_dec;
                        rd_nx     = bus.io_read_strobe;
                        cs_nx     = cs_dec;
                        wr_nx     = bus.io_write_strobe;
                        rdp_nx    = bus.io_read_strobe;
                        be_nx     = bus.io_byte_enable;
                        addr_nx   = word_dec;
                        wd_nx     = bus.io_write_data;
                    end else begin
                        // Out-of-window or malformed strobe: complete at once with zero data
                        state_nx  = RESP;
                        ready_nx  = 1'b1;
                        rdata_nx  = '0;
                        err_set   = 1'b1;
                    end
                end
            end
            REQ: begin
                if (rd_q && (RD_LAT != 0)) begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_W'(RD_LAT - 1);
                end else begin
                    state_nx = RESP;
                    ready_nx = 1'b1;
                    if (rd_q) begin
                        rdata_nx = mux_data;
                    end
                    cs_nx    = '0;
                    be_nx    = '0;
                    addr_nx  = '0;
                    wd_nx    = '0;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_nx = RESP;
                    ready_nx = 1'b1;
                    rdata_nx = mux_data;
                    cs_nx    = '0;
                    be_nx    = '0;
                    addr_nx  = '0;
                    wd_nx    = '0;
                end else begin
                    cnt_nx = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A strobe while a transaction is in flight is dropped but reported
        if (bus.io_addr_strobe && (state_q != IDLE)) begin
            err_set = 1'b1;
        end

        busy_nx = (state_nx != IDLE);

        if (err_set) begin
            err_nx = 1'b1;
        end else if (err_clr) begin
            err_nx = 1'b0;
        end else begin
            err_nx = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            region_q <= '0;
            rd_q     <= 1'b0;
            cs_q     <= '0;
            wr_q     <= 1'b0;
            rdp_q    <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wd_q     <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_nx;
            cnt_q    <= cnt_nx;
            region_q <= region_nx;
            rd_q     <= rd_nx;
            cs_q     <= cs_nx;
            wr_q     <= wr_nx;
            rdp_q    <= rdp_nx;
            be_q     <= be_nx;
            addr_q   <= addr_nx;
            wd_q     <= wd_nx;
            ready_q  <= ready_nx;
            rdata_q  <= rdata_nx;
            busy_q   <= busy_nx;
            err_q    <= err_nx;
        end
    end

    assign bus.fp_cs        = cs_q;
    assign bus.fp_wr        = wr_q;
    assign bus.fp_rd        = rdp_q;
    assign bus.fp_be        = be_q;
    assign bus.fp_addr      = addr_q;
    assign bus.fp_wr_data   = wd_q;
    assign bus.io_ready     = ready_q;
    assign bus.io_read_data = rdata_q;
    assign busy             = busy_q;
    assign bus_err          = err_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_mcs_fpro_bridge_gen.sv
// Directed bench for mcs_fpro_bridge_gen across three parameter sets:
// A (N_CS=2, RD_LAT=0), B (N_CS=2, RD_LAT=3), C (N_CS=4, RD_LAT=1, ADDR_W=20).
module tb_mcs_fpro_bridge_gen;
  import fpro_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic busy_a, err_a, clr_a;
  logic busy_b, err_b, clr_b;
  logic busy_c, err_c, clr_c;
  bridge_state_t st_a, st_b, st_c;

  mcs_fpro_bridge_gen_if #(.N_CS(2), .ADDR_W(21)) if_a ();
  mcs_fpro_bridge_gen_if #(.N_CS(2), .ADDR_W(21)) if_b ();
  mcs_fpro_bridge_gen_if #(.N_CS(4), .ADDR_W(20)) if_c ();

  mcs_fpro_bridge_gen #(.BRG_BASE(32'hC000_0000), .N_CS(2), .ADDR_W(21), .RD_LAT(0)) u_a (
    .clk(clk), .rst(rst), .bus(if_a), .busy(busy_a), .bus_err(err_a), .err_clr(clr_a), .dbg_state(st_a));
  mcs_fpro_bridge_gen #(.BRG_BASE(32'hC000_0000), .N_CS(2), .ADDR_W(21), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst), .bus(if_b), .busy(busy_b), .bus_err(err_b), .err_clr(clr_b), .dbg_state(st_b));
  mcs_fpro_bridge_gen #(.BRG_BASE(32'hC000_0000), .N_CS(4), .ADDR_W(20), .RD_LAT(1)) u_c (
    .clk(clk), .rst(rst), .bus(if_c), .busy(busy_c), .bus_err(err_c), .err_clr(clr_c), .dbg_state(st_c));

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive_idle();
    if_a.io_addr_strobe = 0; if_a.io_read_strobe = 0; if_a.io_write_strobe = 0;
    if_b.io_addr_strobe = 0; if_b.io_read_strobe = 0; if_b.io_write_strobe = 0;
    if_c.io_addr_strobe = 0; if_c.io_read_strobe = 0; if_c.io_write_strobe = 0;
    clr_a = 0; clr_b = 0; clr_c = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++; if (if_a.io_ready !== 1'b0) begin failures++; $display("FAIL rst_ready act=%0h exp=0", if_a.io_ready); end
    checks++; if (if_a.io_read_data !== 32'h0) begin failures++; $display("FAIL rst_rdata act=%0h exp=0", if_a.io_read_data); end
    checks++; if (if_a.fp_cs !== 2'b00 || if_a.fp_wr !== 1'b0 || if_a.fp_rd !== 1'b0) begin failures++; $display("FAIL rst_fp act=%0h/%0h/%0h exp=0/0/0", if_a.fp_cs, if_a.fp_wr, if_a.fp_rd); end
    checks++; if (if_a.fp_addr !== 21'h0 || if_a.fp_be !== 4'h0 || if_a.fp_wr_data !== 32'h0) begin failures++; $display("FAIL rst_fp_bus act=%0h/%0h/%0h exp=0/0/0", if_a.fp_addr, if_a.fp_be, if_a.fp_wr_data); end
    checks++; if (busy_a !== 1'b0 || err_a !== 1'b0 || st_a !== IDLE) begin failures++; $display("FAIL rst_status act=%0h/%0h/%0d exp=0/0/0", busy_a, err_a, st_a); end
    checks++; if (busy_b !== 1'b0 || busy_c !== 1'b0 || if_c.fp_cs !== 4'h0) begin failures++; $display("FAIL rst_bc act=%0h/%0h/%0h exp=0/0/0", busy_b, busy_c, if_c.fp_cs); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    if_a.io_addr_strobe = 1; if_a.io_write_strobe = 1; if_a.io_read_strobe = 0;
    if_a.io_address = 32'hC000_0010; if_a.io_write_data = 32'hA5A5_1234; if_a.io_byte_enable = 4'b0011;
    tick(); drive_idle();
    checks++; if (st_a !== REQ) begin failures++; $display("FAIL wr_state_req act=%0d exp=%0d", st_a, REQ); end
    checks++; if (if_a.fp_cs !== 2'b01) begin failures++; $display("FAIL wr_cs act=%0b exp=01", if_a.fp_cs); end
    checks++; if (if_a.fp_wr !== 1'b1 || if_a.fp_rd !== 1'b0) begin failures++; $display("FAIL wr_strobes act=%0h/%0h exp=1/0", if_a.fp_wr, if_a.fp_rd); end
    checks++; if (if_a.fp_addr !== 21'h4) begin failures++; $display("FAIL wr_addr act=%0h exp=4", if_a.fp_addr); end
    checks++; if (if_a.fp_be !== 4'b0011) begin failures++; $display("FAIL wr_be act=%0b exp=0011", if_a.fp_be); end
    checks++; if (if_a.fp_wr_data !== 32'hA5A5_1234) begin failures++; $display("FAIL wr_data act=%0h exp=a5a51234", if_a.fp_wr_data); end
    checks++; if (if_a.io_ready !== 1'b0 || busy_a !== 1'b1) begin failures++; $display("FAIL wr_t1_ready_busy act=%0h/%0h exp=0/1", if_a.io_ready, busy_a); end
    tick();
    checks++; if (if_a.io_ready !== 1'b1) begin failures++; $display("FAIL wr_ready_t2 act=%0h exp=1", if_a.io_ready); end
    checks++; if (if_a.io_read_data !== 32'h0) begin failures++; $display("FAIL wr_rdata_kept act=%0h exp=0", if_a.io_read_data); end
    checks++; if (if_a.fp_cs !== 2'b00 || if_a.fp_wr !== 1'b0 || if_a.fp_addr !== 21'h0 || if_a.fp_be !== 4'h0 || if_a.fp_wr_data !== 32'h0) begin
      failures++; $display("FAIL wr_resp_clear act=%0h/%0h/%0h/%0h/%0h exp=0", if_a.fp_cs, if_a.fp_wr, if_a.fp_addr, if_a.fp_be, if_a.fp_wr_data); end
    tick();
    checks++; if (if_a.io_ready !== 1'b0 || st_a !== IDLE || busy_a !== 1'b0) begin failures++; $display("FAIL wr_back_idle act=%0h/%0d/%0h exp=0/0/0", if_a.io_ready, st_a, busy_a); end
  endtask

  task automatic test_read_zero_lat();
    if_a.io_addr_strobe = 1; if_a.io_read_strobe = 1; if_a.io_address = 32'hC080_0004;
    tick(); drive_idle();
    checks++; if (if_a.fp_cs !== 2'b10 || if_a.fp_rd !== 1'b1 || if_a.fp_addr !== 21'h1) begin failures++; $display("FAIL rd0_req act=%0b/%0h/%0h exp=10/1/1", if_a.fp_cs, if_a.fp_rd, if_a.fp_addr); end
    tick();
    checks++; if (if_a.io_ready !== 1'b1 || if_a.io_read_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd0_resp act=%0h/%0h exp=1/deadbeef", if_a.io_ready, if_a.io_read_data); end
    tick();
    // a following write must leave the captured read value alone
    if_a.io_addr_strobe = 1; if_a.io_write_strobe = 1; if_a.io_address = 32'hC000_0000;
    if_a.io_write_data = 32'h0000_1234; if_a.io_byte_enable = 4'b1111;
    tick(); drive_idle();
    tick();
    checks++; if (if_a.io_ready !== 1'b1 || if_a.io_read_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd0_wr_keeps act=%0h/%0h exp=1/deadbeef", if_a.io_ready, if_a.io_read_data); end
    tick();
  endtask

  task automatic test_read_latency();
    if_b.io_addr_strobe = 1; if_b.io_read_strobe = 1; if_b.io_address = 32'hC080_0008; if_b.io_byte_enable = 4'b1111;
    tick(); drive_idle();
    checks++; if (if_b.fp_cs !== 2'b10 || if_b.fp_rd !== 1'b1 || if_b.fp_addr !== 21'h2) begin failures++; $display("FAIL rd3_req act=%0b/%0h/%0h exp=10/1/2", if_b.fp_cs, if_b.fp_rd, if_b.fp_addr); end
    tick();
    checks++; if (st_b !== WAIT || if_b.fp_rd !== 1'b0 || if_b.fp_cs !== 2'b10) begin failures++; $display("FAIL rd3_wait act=%0d/%0h/%0b exp=%0d/0/10", st_b, if_b.fp_rd, if_b.fp_cs, WAIT); end
    tick(); tick();
    checks++; if (if_b.io_ready !== 1'b0) begin failures++; $display("FAIL rd3_early_ready act=%0h exp=0", if_b.io_ready); end
    tick();
    checks++; if (if_b.io_ready !== 1'b1 || if_b.io_read_data !== 32'h1122_3344) begin failures++; $display("FAIL rd3_resp act=%0h/%0h exp=1/11223344", if_b.io_ready, if_b.io_read_data); end
    checks++; if (if_b.fp_cs !== 2'b00) begin failures++; $display("FAIL rd3_cs_clear act=%0b exp=00", if_b.fp_cs); end
    tick();
    checks++; if (if_b.io_ready !== 1'b0 || if_b.io_read_data !== 32'h1122_3344) begin failures++; $display("FAIL rd3_hold act=%0h/%0h exp=0/11223344", if_b.io_ready, if_b.io_read_data); end
  endtask

  task automatic test_miss();
    if_a.io_addr_strobe = 1; if_a.io_read_strobe = 1; if_a.io_address = 32'h8000_0000;
    tick(); drive_idle();
    checks++; if (if_a.io_ready !== 1'b1 || if_a.io_read_data !== 32'h0) begin failures++; $display("FAIL miss_resp act=%0h/%0h exp=1/0", if_a.io_ready, if_a.io_read_data); end
    checks++; if (if_a.fp_cs !== 2'b00 || if_a.fp_rd !== 1'b0 || err_a !== 1'b1) begin failures++; $display("FAIL miss_fp_err act=%0b/%0h/%0h exp=00/0/1", if_a.fp_cs, if_a.fp_rd, err_a); end
    tick(); tick();
    checks++; if (err_a !== 1'b1 || if_a.io_ready !== 1'b0) begin failures++; $display("FAIL miss_sticky act=%0h/%0h exp=1/0", err_a, if_a.io_ready); end
    clr_a = 1;
    tick(); drive_idle();
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL miss_clr act=%0h exp=0", err_a); end
    // clear and a new miss in the same cycle: set wins
    clr_a = 1; if_a.io_addr_strobe = 1; if_a.io_read_strobe = 1; if_a.io_address = 32'h8000_0000;
    tick(); drive_idle();
    checks++; if (err_a !== 1'b1 || if_a.io_ready !== 1'b1) begin failures++; $display("FAIL miss_set_wins act=%0h/%0h exp=1/1", err_a, if_a.io_ready); end
    tick();
    clr_a = 1;
    tick(); drive_idle();
    // both qualifiers on an in-window address is malformed
    if_a.io_addr_strobe = 1; if_a.io_read_strobe = 1; if_a.io_write_strobe = 1; if_a.io_address = 32'hC000_0000;
    tick(); drive_idle();
    checks++; if (if_a.io_ready !== 1'b1 || if_a.fp_wr !== 1'b0 || if_a.fp_cs !== 2'b00 || err_a !== 1'b1) begin
      failures++; $display("FAIL both_qual act=%0h/%0h/%0b/%0h exp=1/0/00/1", if_a.io_ready, if_a.fp_wr, if_a.fp_cs, err_a); end
    tick();
    clr_a = 1;
    tick(); drive_idle();
  endtask

  task automatic test_ignored_strobe();
    checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL ign_pre_err act=%0h exp=0", err_b); end
    if_b.io_addr_strobe = 1; if_b.io_read_strobe = 1; if_b.io_address = 32'hC000_000C;
    tick(); drive_idle();
    tick();
    if_b.io_addr_strobe = 1; if_b.io_write_strobe = 1; if_b.io_address = 32'hC080_0000; if_b.io_write_data = 32'hFFFF_FFFF;
    tick(); drive_idle();
    checks++; if (err_b !== 1'b1 || st_b !== WAIT || if_b.fp_wr !== 1'b0 || if_b.fp_cs !== 2'b01) begin
      failures++; $display("FAIL ign_wait act=%0h/%0d/%0h/%0b exp=1/%0d/0/01", err_b, st_b, if_b.fp_wr, if_b.fp_cs, WAIT); end
    tick();
    checks++; if (if_b.io_ready !== 1'b0) begin failures++; $display("FAIL ign_early act=%0h exp=0", if_b.io_ready); end
    tick();
    checks++; if (if_b.io_ready !== 1'b1 || if_b.io_read_data !== 32'h5555_AAAA) begin failures++; $display("FAIL ign_resp act=%0h/%0h exp=1/5555aaaa", if_b.io_ready, if_b.io_read_data); end
    tick();
    checks++; if (st_b !== IDLE || if_b.io_ready !== 1'b0 || err_b !== 1'b1) begin failures++; $display("FAIL ign_after act=%0d/%0h/%0h exp=0/0/1", st_b, if_b.io_ready, err_b); end
  endtask

  task automatic test_reset_mid();
    if_b.io_addr_strobe = 1; if_b.io_read_strobe = 1; if_b.io_address = 32'hC080_0000;
    tick(); drive_idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (st_b !== IDLE || busy_b !== 1'b0 || err_b !== 1'b0) begin failures++; $display("FAIL rstmid_state act=%0d/%0h/%0h exp=0/0/0", st_b, busy_b, err_b); end
    checks++; if (if_b.fp_cs !== 2'b00 || if_b.fp_rd !== 1'b0 || if_b.io_ready !== 1'b0 || if_b.io_read_data !== 32'h0) begin
      failures++; $display("FAIL rstmid_outs act=%0b/%0h/%0h/%0h exp=00/0/0/0", if_b.fp_cs, if_b.fp_rd, if_b.io_ready, if_b.io_read_data); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (if_b.io_ready !== 1'b0) begin failures++; $display("FAIL rstmid_no_ready act=%0h exp=0", if_b.io_ready); end
    end
    if_b.io_addr_strobe = 1; if_b.io_write_strobe = 1; if_b.io_address = 32'hC080_0010;
    if_b.io_write_data = 32'hCAFE_0001; if_b.io_byte_enable = 4'b1111;
    tick(); drive_idle();
    checks++; if (if_b.fp_cs !== 2'b10 || if_b.fp_wr !== 1'b1 || if_b.fp_addr !== 21'h4 || if_b.fp_wr_data !== 32'hCAFE_0001) begin
      failures++; $display("FAIL rstmid_wr_req act=%0b/%0h/%0h/%0h exp=10/1/4/cafe0001", if_b.fp_cs, if_b.fp_wr, if_b.fp_addr, if_b.fp_wr_data); end
    tick();
    checks++; if (if_b.io_ready !== 1'b1) begin failures++; $display("FAIL rstmid_wr_ready act=%0h exp=1", if_b.io_ready); end
    tick();
  endtask

  task automatic test_back_to_back();
    if_c.io_addr_strobe = 1; if_c.io_write_strobe = 1; if_c.io_address = 32'hC0C0_0000;
    if_c.io_write_data = 32'h0F0F_0F0F; if_c.io_byte_enable = 4'b1100;
    tick(); drive_idle();
    checks++; if (if_c.fp_cs !== 4'b1000 || if_c.fp_wr !== 1'b1 || if_c.fp_addr !== 20'h0 || if_c.fp_be !== 4'b1100) begin
      failures++; $display("FAIL b2b_wr_req act=%0b/%0h/%0h/%0b exp=1000/1/0/1100", if_c.fp_cs, if_c.fp_wr, if_c.fp_addr, if_c.fp_be); end
    tick();
    checks++; if (if_c.io_ready !== 1'b1) begin failures++; $display("FAIL b2b_wr_ready act=%0h exp=1", if_c.io_ready); end
    tick();
    if_c.io_addr_strobe = 1; if_c.io_read_strobe = 1; if_c.io_address = 32'hC0C0_0004;
    tick(); drive_idle();
    checks++; if (if_c.fp_cs !== 4'b1000 || if_c.fp_rd !== 1'b1 || if_c.fp_addr !== 20'h1) begin
      failures++; $display("FAIL b2b_rd_req act=%0b/%0h/%0h exp=1000/1/1", if_c.fp_cs, if_c.fp_rd, if_c.fp_addr); end
    tick();
    checks++; if (if_c.io_ready !== 1'b0 || st_c !== WAIT) begin failures++; $display("FAIL b2b_rd_wait act=%0h/%0d exp=0/%0d", if_c.io_ready, st_c, WAIT); end
    tick();
    checks++; if (if_c.io_ready !== 1'b1 || if_c.io_read_data !== 32'h3333_3333) begin failures++; $display("FAIL b2b_rd_resp act=%0h/%0h exp=1/33333333", if_c.io_ready, if_c.io_read_data); end
    tick();
    if_c.io_addr_strobe = 1; if_c.io_read_strobe = 1; if_c.io_address = 32'hC080_0000;
    tick(); drive_idle();
    checks++; if (if_c.fp_cs !== 4'b0100 || if_c.fp_rd !== 1'b1) begin failures++; $display("FAIL b2b_r2_req act=%0b/%0h exp=0100/1", if_c.fp_cs, if_c.fp_rd); end
    tick(); tick();
    checks++; if (if_c.io_ready !== 1'b1 || if_c.io_read_data !== 32'h2222_2222) begin failures++; $display("FAIL b2b_r2_resp act=%0h/%0h exp=1/22222222", if_c.io_ready, if_c.io_read_data); end
    tick();
  endtask

  initial begin
    drive_idle();
    if_a.io_address = '0; if_a.io_write_data = '0; if_a.io_byte_enable = '0;
    if_b.io_address = '0; if_b.io_write_data = '0; if_b.io_byte_enable = '0;
    if_c.io_address = '0; if_c.io_write_data = '0; if_c.io_byte_enable = '0;
    if_a.fp_rd_data = {32'hDEAD_BEEF, 32'h0BAD_F00D};
    if_b.fp_rd_data = {32'h1122_3344, 32'h5555_AAAA};
    if_c.fp_rd_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0001};

    test_reset();
    test_write();
    test_read_zero_lat();
    test_read_latency();
    test_miss();
    test_ignored_strobe();
    test_reset_mid();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcs_fpro_bridge_gen.md
Name: mcs_fpro_bridge_gen

Overview:
Parametrised, registered bridge from the MicroBlaze MCS IO bus to the FPro bus. It is the successor to the fixed two-region, zero-wait bridge. It decodes N_CS chip-select regions, forwards byte enables, and waits a configurable slave read latency before returning data. It flags out-of-window and protocol-violation accesses. It sits between the cpu instance and the mmio/video subsystems in the top level.

Parameters:
BRG_BASE, 32'hC000_0000, bridge window base; only bits [31:24] are compared.
N_CS, 2, number of FPro chip-select regions (1..8).
ADDR_W, 21, FPro word-address width; ADDR_W+2+clog2(N_CS) must be <= 24.
RD_LAT, 0, slave read latency in cycles after the fp_rd pulse (0..7).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
io_addr_strobe  in  1  MCS access start
io_read_strobe  in  1  MCS read qualifier
io_write_strobe  in  1  MCS write qualifier
io_byte_enable  in  4  MCS byte lanes
io_address  in  32  MCS byte address
io_write_data  in  32  MCS write data
io_read_data  out  32  registered read data to MCS
io_ready  out  1  single-cycle completion pulse
fp_cs  out  N_CS  one-hot region select
fp_wr  out  1  FPro write pulse
fp_rd  out  1  FPro read pulse
fp_be  out  4  FPro byte enables
fp_addr  out  ADDR_W  FPro word address
fp_wr_data  out  32  FPro write data
fp_rd_data  in  N_CS*32  per-region read data; region k occupies [32k+31:32k]
busy  out  1  high in any state other than IDLE
bus_err  out  1  sticky error flag
err_clr  in  1  clears bus_err

Behaviour:
- Reset values: all outputs 0. State goes to IDLE and the latency counter is cleared.
- Reset asserted mid-transaction: the transaction is dropped. No io_ready is issued. fp strobes are 0 from the next edge.
- All outputs are registered.
- Decode:
  - hit = (io_address[31:24] == BRG_BASE[31:24]).
  - region = io_address[23 -: clog2(N_CS)] (0 when N_CS=1).
  - word address = io_address[ADDR_W+1:2].
  - A region index >= N_CS is treated as a miss.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - A transaction starts when io_addr_strobe is high together with io_read_strobe or io_write_strobe.
  - On hit, latch address, region, write data, byte enables and direction, then go to REQ.
  - On miss, go to RESP with read data forced to 0 and bus_err set.
  - A strobe with both qualifiers high, or with neither, is also treated as a miss.
- REQ (one cycle):
  - fp_cs[region]=1; fp_wr or fp_rd=1; fp_addr, fp_be and fp_wr_data are valid.
  - Writes go to RESP.
  - Reads go to RESP if RD_LAT=0 and capture fp_rd_data[region] this cycle; otherwise go to WAIT with counter = RD_LAT-1.
- WAIT:
  - fp_cs stays held; fp_rd=0 and fp_wr=0.
  - The counter decrements each cycle. When it reaches 0, capture fp_rd_data[region] and go to RESP.
- RESP:
  - io_ready=1 for exactly one cycle.
  - io_read_data carries the captured value for reads (0 for a miss). It is unchanged for writes.
  - Next state is IDLE.
- io_read_data holds its value until the next read completes.
- Latency, counted from the strobe cycle t0: hit write → io_ready at t0+2; hit read → t0+2+RD_LAT; miss → t0+1.
- fp_cs, fp_addr, fp_be and fp_wr_data return to 0 in RESP.
- io_addr_strobe in any non-IDLE state: the strobe is ignored, bus_err is set, and the current transaction is unaffected.
- A new strobe in the cycle after RESP (i.e. in IDLE) is accepted normally.
- bus_err:
  - Set by a miss or an ignored strobe.
  - Cleared by err_clr.
  - If set and clear happen in the same cycle, set wins.

Decomposition:
- Shared package fpro_bus_pkg holds:
  - the state enum bridge_state_t {IDLE, REQ, WAIT, RESP};
  - FP_DATA_W=32 and FP_BE_W=4;
  - the address-field localparams (window MSB 31, region MSB 23, word LSB 2).
- One sub-module, fpro_rd_mux: parametrised N_CS-way read-data mux selected by the latched region.

Test Plan:
1. RD_LAT=0; write to 0xC000_0010, data 0xA5A5_1234, be=4'b0011 → REQ at t0+1 with fp_cs=2'b01, fp_wr=1, fp_addr=0x4, fp_be=4'b0011; io_ready at t0+2; io_read_data unchanged.
2. RD_LAT=3; read from 0xC080_0008 with slave 1 driving 0x1122_3344 → fp_cs=2'b10, fp_rd pulses at t0+1; io_ready with io_read_data=0x1122_3344 at t0+5.
3. Read from 0x8000_0000 → no fp_cs activity; io_ready at t0+1 with data 0; bus_err=1 until err_clr; err_clr simultaneous with a new miss leaves bus_err=1.
4. Second io_addr_strobe issued during WAIT → ignored; first read completes with correct data; bus_err=1.
5. rst asserted during WAIT → next cycle all outputs 0; no io_ready; a subsequent write completes at t0+2.
6. Back-to-back write then read, with the strobe issued the cycle after io_ready → both complete with correct latencies; N_CS=4 region 3 (address 0xC0C0_0000) drives fp_cs=4'b1000.
